// File: rtl/igmp_pkg.sv
// Shared definitions for the IGMP receive path: header geometry, checksum
// constant and the header assembler state encoding.
package igmp_pkg;

   localparam int unsigned HDR_BYTES = 16;
   localparam int unsigned ACC_W     = 24;
   localparam logic [15:0] CSUM_GOOD = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      DRAIN,
      FINAL,
      HOLD
   } state_e;

endpackage

// File: rtl/igmp_csum_accum.sv
// Byte-serial one's-complement accumulator: pairs even/odd bytes into 16-bit
// words, pads a trailing odd byte with zero and folds the sum to 16 bits.
module igmp_csum_accum
   import igmp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        byte_vld_i,
   input  logic [7:0]  byte_i,
   output logic [15:0] fold_o
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       hi_q, hi_d;
   logic             odd_q, odd_d;
   logic [ACC_W:0]   total;
   logic [16:0]      fold1;

   // A clear with a byte present restarts pairing with that byte as index 0.
   always_comb begin
      acc_d = acc_q;
      hi_d  = hi_q;
      odd_d = odd_q;
      if (clr_i) begin
         acc_d = '0;
         hi_d  = '0;
         odd_d = 1'b0;
         if (byte_vld_i) begin
            hi_d  = byte_i;
            odd_d = 1'b1;
         end
      end else if (byte_vld_i) begin
         if (odd_q) begin
            acc_d = acc_q + ACC_W'({hi_q, byte_i});
            odd_d = 1'b0;
         end else begin
            hi_d  = byte_i;
            odd_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         hi_q  <= '0;
         odd_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         hi_q  <= hi_d;
         odd_q <= odd_d;
      end
   end

   // Pending high byte counts as a zero-padded word; two end-around folds suffice.
   always_comb begin
      total  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(odd_q ? {hi_q, 8'h00} : 16'h0000);
      fold1  = {1'b0, total[15:0]} + 17'(total[ACC_W:16]);
      fold_o = fold1[15:0] + 16'(fold1[16]);
   end

endmodule

// File: rtl/igmp_header_assembler.sv
// Packs the first 16 bytes of an IGMP message into four header words and
// reports checksum and length status with a ready/valid header handshake.
module igmp_header_assembler
   import igmp_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_sop,
   input  logic        in_eop,
   output logic        in_ready,
   output logic [31:0] h1,
   output logic [31:0] h2,
   output logic [31:0] h3,
   output logic [31:0] h4,
   output logic        hdr_valid,
   input  logic        hdr_ready,
   output logic        csum_ok,
   output logic        len_err
);

   localparam int unsigned      CNT_W    = $clog2(MAX_BYTES + 2);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BYTES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(HDR_BYTES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HDR_BYTES - 1);

   state_e                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       ovf_q, ovf_d;
   logic [8*HDR_BYTES-1:0]     hdr_q, hdr_d;
   logic                       csum_ok_q, csum_ok_d;
   logic                       len_err_q, len_err_d;
   logic                       hdr_valid_q, hdr_valid_d;
   logic                       in_ready_q, in_ready_d;
   logic                       accept;
   logic                       acc_clr;
   logic                       acc_vld;
   logic [6:0]                 bpos;
   logic [15:0]                fold;

   igmp_csum_accum u_csum (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (acc_clr),
      .byte_vld_i (acc_vld),
      .byte_i     (in_data),
      .fold_o     (fold)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      hdr_d     = hdr_q;
      csum_ok_d = csum_ok_q;
      len_err_d = len_err_q;
      acc_clr   = 1'b0;
      acc_vld   = 1'b0;
      accept    = in_valid && in_ready_q;
      bpos      = {~cnt_q[3:0], 3'b000};
      case (state_q)
         IDLE, COLLECT, DRAIN: begin
            if (accept) begin
               if (in_sop) begin
                  hdr_d                  = '0;
                  hdr_d[8*HDR_BYTES-1 -: 8] = in_data;
                  cnt_d                  = CNT_W'(1);
                  ovf_d                  = 1'b0;
                  acc_clr                = 1'b1;
                  acc_vld                = 1'b1;
                  state_d                = in_eop ? FINAL : COLLECT;
               end else if (state_q != IDLE) begin
                  if (cnt_q < CNT_HDR) hdr_d[bpos +: 8] = in_data;
                  acc_vld = (cnt_q < CNT_MAX);
                  if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q >= CNT_MAX) ovf_d = 1'b1;
                  if (in_eop) state_d = FINAL;
                  else if (state_q == COLLECT && cnt_q == CNT_LAST) state_d = DRAIN;
               end
            end
         end
         FINAL: begin
            csum_ok_d = (fold == CSUM_GOOD);
            len_err_d = (cnt_q < CNT_HDR) || ovf_q;
            state_d   = HOLD;
         end
         HOLD: begin
            if (hdr_valid_q && hdr_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Valid asserts on the second cycle of HOLD, once the flags are registered.
      hdr_valid_d = (state_q == HOLD) && (state_d == HOLD);
      in_ready_d  = (state_d == IDLE) || (state_d == COLLECT) || (state_d == DRAIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         hdr_q       <= '0;
         csum_ok_q   <= 1'b0;
         len_err_q   <= 1'b0;
         hdr_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         hdr_q       <= hdr_d;
         csum_ok_q   <= csum_ok_d;
         len_err_q   <= len_err_d;
         hdr_valid_q <= hdr_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign h1        = hdr_q[127:96];
   assign h2        = hdr_q[95:64];
   assign h3        = hdr_q[63:32];
   assign h4        = hdr_q[31:0];
   assign hdr_valid = hdr_valid_q;
   assign in_ready  = in_ready_q;
   assign csum_ok   = csum_ok_q;
   assign len_err   = len_err_q;

endmodule

// File: tb/tb_igmp_header_assembler.sv
// Directed bench for igmp_header_assembler: expected headers are queued when a
// message is sent and compared when the consumer takes the header.
module tb_igmp_header_assembler;

   localparam int unsigned MAXB = 64;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [31:0] h1, h2, h3, h4;
      logic        ok;
      logic        le;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_sop = 1'b0;
   logic        in_eop = 1'b0;
   logic        in_ready;
   logic [31:0] h1, h2, h3, h4;
   logic        hdr_valid;
   logic        hdr_ready = 1'b1;
   logic        csum_ok;
   logic        len_err;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned hdrs_seen = 0;
   exp_t        sb[$];

   igmp_header_assembler #(.MAX_BYTES(MAXB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_sop    (in_sop),
      .in_eop    (in_eop),
      .in_ready  (in_ready),
      .h1        (h1),
      .h2        (h2),
      .h3        (h3),
      .h4        (h4),
      .hdr_valid (hdr_valid),
      .hdr_ready (hdr_ready),
      .csum_ok   (csum_ok),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input bq_t b);
      exp_t          e;
      logic [127:0]  h = '0;
      int unsigned   sum = 0;
      int unsigned   w;
      for (int i = 0; i < b.size(); i++) begin
         if (i < 16) h[127-8*i -: 8] = b[i];
         if (i < MAXB) begin
            w = b[i];
            sum += (i % 2 == 0) ? (w << 8) : w;
         end
      end
      while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
      e.h1 = h[127:96];
      e.h2 = h[95:64];
      e.h3 = h[63:32];
      e.h4 = h[31:0];
      e.ok = (sum == 32'hFFFF);
      e.le = (b.size() < 16) || (b.size() > MAXB);
      return e;
   endfunction

   function automatic exp_t mk(input logic [31:0] a, b, c, d, input logic ok, le);
      exp_t e;
      e.h1 = a; e.h2 = b; e.h3 = c; e.h4 = d; e.ok = ok; e.le = le;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
      int unsigned t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_sop   = s;
      in_eop   = e;
      @(negedge clk);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
   endtask

   task automatic send_msg(input bq_t b);
      for (int i = 0; i < b.size(); i++)
         send_byte(b[i], i == 0, i == b.size() - 1);
   endtask

   task automatic wait_drain(input string tag);
      int unsigned t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_h1"}, h1, 32'd0);
      chk({tag, "_h4"}, h4, 32'd0);
      chk({tag, "_hv"}, {31'd0, hdr_valid}, 32'd0);
      chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_ok"}, {31'd0, csum_ok}, 32'd0);
      chk({tag, "_le"}, {31'd0, len_err}, 32'd0);
   endtask

   // Header consumer side: compare every taken header against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst && hdr_valid && hdr_ready) begin
         hdrs_seen++;
         chk("unexpected_header", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("h1", h1, e.h1);
            chk("h2", h2, e.h2);
            chk("h3", h3, e.h3);
            chk("h4", h4, e.h4);
            chk("csum_ok", {31'd0, csum_ok}, {31'd0, e.ok});
            chk("len_err", {31'd0, len_err}, {31'd0, e.le});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t         q, qm, sh, qo, tmp;
      int unsigned t;
      int unsigned seen0;
      q  = '{8'h11, 8'h0A, 8'hCB, 8'h6C, 8'hAA, 8'hDD, 8'h5B, 8'h5B,
             8'h0A, 8'h80, 8'h00, 8'h01, 8'hD6, 8'hD7, 8'h3B, 8'hF7};
      qm = q;
      qm[3] = 8'h6D;
      sh = '{8'h11, 8'h0A, 8'h00, 8'h00, 8'hAA, 8'hDD};
      // 17 bytes: trailing odd byte 01 pads to 0100, offset by 3B -> 3A.
      qo = q;
      qo[14] = 8'h3A;
      qo.push_back(8'h01);

      // Reset state
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      chk("ready_lag", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("ready_rise", {31'd0, in_ready}, 32'd1);

      // Valid query with latency check: eop at edge N, valid from N+2 for one cycle
      sb.push_back(mk(32'h110ACB6C, 32'hAADD5B5B, 32'h0A800001, 32'hD6D73BF7, 1'b1, 1'b0));
      send_msg(q);
      chk("final_hv", {31'd0, hdr_valid}, 32'd0);
      chk("final_rdy", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("hold1_hv", {31'd0, hdr_valid}, 32'd0);
      @(negedge clk);
      chk("hold2_hv", {31'd0, hdr_valid}, 32'd1);
      @(negedge clk);
      chk("post_hv", {31'd0, hdr_valid}, 32'd0);
      chk("post_rdy", {31'd0, in_ready}, 32'd1);
      wait_drain("drain_query");

      // Corrupted byte 3
      sb.push_back(mk(32'h110ACB6D, 32'hAADD5B5B, 32'h0A800001, 32'hD6D73BF7, 1'b0, 1'b0));
      send_msg(qm);
      wait_drain("drain_bad");

      // Short message
      sb.push_back(mk(32'h110A0000, 32'hAADD0000, 32'h0, 32'h0, 1'b0, 1'b1));
      send_msg(sh);
      wait_drain("drain_short");

      // Backpressure
      hdr_ready = 1'b0;
      sb.push_back(mk(32'h110ACB6C, 32'hAADD5B5B, 32'h0A800001, 32'hD6D73BF7, 1'b1, 1'b0));
      send_msg(q);
      t = 0;
      while (!hdr_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp_hv", {31'd0, hdr_valid}, 32'd1);
         chk("bp_h1", h1, 32'h110ACB6C);
         chk("bp_h4", h4, 32'hD6D73BF7);
         chk("bp_rdy", {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      hdr_ready = 1'b1;
      sb.push_back(model(qo));
      send_msg(qo);
      wait_drain("drain_bp");

      // Restart at byte 7
      seen0 = hdrs_seen;
      sb.push_back(model(q));
      for (int i = 0; i < 7; i++) send_byte(8'(8'h40 + i), i == 0, 1'b0);
      send_msg(q);
      wait_drain("drain_restart");
      chk("restart_count", hdrs_seen - seen0, 32'd1);

      // Length boundaries
      foreach (tmp[i]) tmp.delete();
      for (int n = 0; n < 70; n++) tmp.push_back(8'(n * 7 + 3));
      sb.push_back(model(tmp));
      send_msg(tmp);
      wait_drain("drain_70");
      tmp = tmp[0:64];
      sb.push_back(model(tmp));
      send_msg(tmp);
      wait_drain("drain_65");
      tmp = tmp[0:63];
      sb.push_back(model(tmp));
      send_msg(tmp);
      wait_drain("drain_64");
      chk("len64_model", {31'd0, model(tmp).le}, 32'd0);

      // Reset during COLLECT
      seen0 = hdrs_seen;
      for (int i = 0; i < 8; i++) send_byte(q[i], i == 0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("rst_collect");
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_collect_count", hdrs_seen - seen0, 32'd0);

      // Reset during HOLD
      hdr_ready = 1'b0;
      send_msg(sh);
      t = 0;
      while (!hdr_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("rst_hold_pre", {31'd0, hdr_valid}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("rst_hold");
      hdr_ready = 1'b1;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_hold_count", hdrs_seen - seen0, 32'd0);
      chk("sb_final", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/igmp_header_assembler.md
# igmp_header_assembler

Upstream stage of the IGMP receive path: accepts an IGMP message as a byte stream with start/end markers, packs the first 16 bytes into the four 32-bit header words consumed by the IGMP receiver, and verifies the one's-complement checksum over the whole message. It presents one header per message with a ready/valid handshake, plus checksum and length status flags.

## Interface
- MAX_BYTES, 64, largest accepted message length in bytes; must be ≥16.
- HDR_BYTES, 16, header bytes packed into h1..h4. Fixed; not overridable.
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  byte present on in_data.
- in_data  in  8  message byte, network order.
- in_sop  in  1  first byte of message; qualified by in_valid.
- in_eop  in  1  last byte of message; qualified by in_valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- h1, h2, h3, h4  out  32 each  message bytes 0-3, 4-7, 8-11, 12-15; byte 0 in h1[31:24].
- hdr_valid  out  1  h1..h4 and flags valid.
- hdr_ready  in  1  consumer takes header when hdr_valid && hdr_ready.
- csum_ok  out  1  folded message sum equals 16'hFFFF.
- len_err  out  1  message shorter than 16 bytes or longer than MAX_BYTES.

## Operation
- States: IDLE, COLLECT, DRAIN, FINAL, HOLD.
- IDLE: in_ready=1. Accepted byte without in_sop is dropped. Accepted byte with in_sop clears header registers, count and accumulator, stores byte 0, then goes to COLLECT. If in_eop is on the same beat, go to FINAL.
- COLLECT: stores byte n at its header position. Count 16 moves to DRAIN. in_eop moves to FINAL.
- DRAIN: bytes are checksummed only. in_eop moves to FINAL.
- In COLLECT or DRAIN, an accepted in_sop restarts the message. That byte becomes byte 0 and the partial message is discarded without output.
- Checksum: even-index byte is the high half of a 16-bit word and odd-index byte the low half. A trailing odd byte is padded with 8'h00. Words are summed into a ≥24-bit accumulator.
- Byte count saturates at MAX_BYTES+1. A count above MAX_BYTES sets the sticky overflow. Bytes past MAX_BYTES are still consumed until in_eop but are not summed.
- FINAL: in_ready=0. Fold the end-around carry twice to 16 bits. Register csum_ok = (fold==16'hFFFF) and len_err = (count<16) || overflow. Go to HOLD.
- HOLD: in_ready=0, hdr_valid=1. Header and flags are stable until hdr_ready, then go to IDLE.
- For a short message, the missing header bytes read 0.
- Reset: every output is 0 (h1..h4, hdr_valid, csum_ok, len_err, in_ready), state IDLE, count 0, accumulator 0. in_ready rises the cycle after rst deasserts.
- Reset mid-message or during HOLD discards everything. No header is emitted.

## Timing
- One byte per cycle maximum. No bubbles are required.
- in_eop accepted at edge N: FINAL during cycle N..N+1, hdr_valid high from edge N+2.
- hdr_ready sampled high at edge M: hdr_valid low and in_ready high after M.
- Minimum spacing between message headers is 3 cycles plus message length.
- A byte offered while in_ready=0 is held by the source under the handshake rule. The block does not sample it.

## Structure
- Package igmp_pkg: HDR_BYTES=16, state enum (IDLE..HOLD), CSUM_GOOD=16'hFFFF. The downstream receiver shares the header field offsets.
- Sub-module igmp_csum_accum: byte-serial one's-complement accumulator with clear, byte-in, odd/even pairing, pad and fold. Outputs a 16-bit folded sum.
- Top holds the FSM, byte counter, header shift/position registers and handshake.

## Test plan
- Valid query: 16 bytes 11 0A CB 6C AA DD 5B 5B 0A 80 00 01 D6 D7 3B F7, sop on the first, eop on the last, hdr_ready=1. Expect h1=110ACB6C, h2=AADD5B5B, h3=0A800001, h4=D6D73BF7, csum_ok=1, len_err=0, hdr_valid for exactly 1 cycle, 2 edges after eop.
- Same message with byte 3 = 6D. Expect identical h-words except h1=110ACB6D, csum_ok=0.
- Short message: 6 bytes 11 0A 00 00 AA DD. Expect h1=110A0000, h2=AADD0000, h3=h4=0, len_err=1.
- Backpressure: hdr_ready low for 5 cycles. Expect hdr_valid and data stable, in_ready=0 throughout, and the next message accepted only after handshake.
- Restart: in_sop reasserted at byte 7, then a full valid query. Expect exactly one header, matching the second message.
- Overflow and reset: a 70-byte message with MAX_BYTES=64 gives len_err=1. rst pulsed during COLLECT gives no hdr_valid and all outputs 0.
